fetch_unit: RTL and testbench

Parametrised instruction-fetch front end for the pipelined CPU. It replaces the single fetch register with a prefetch queue that decouples instruction-memory reads from decode stalls. It accepts PC redirects from EX (branch/jal/jalr), flushing queued and in-flight fetches. It sits between the word-addressed synchronous instruction memory and the decode/control stage.

---
 rtl/fetch_pkg.sv | 19 +
 rtl/fetch_if.sv | 33 +++
 rtl/fetch_queue.sv | 76 +++++++
 rtl/fetch_unit.sv | 87 ++++++++
 tb/tb_fetch_unit.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// Shared constants and types for the instruction-fetch front end.
// fetch_entry_t is one prefetch queue slot: the PC and the instruction read from it.
package fetch_pkg;

  localparam int PC_W_DEF    = 12;
  localparam int INSTR_W_DEF = 32;
  localparam int DEPTH_DEF   = 4;

  typedef struct packed {
    logic [PC_W_DEF-1:0]    pc;
    logic [INSTR_W_DEF-1:0] instr;
  } fetch_entry_t;

  // Occupancy counters need one extra bit so a completely full queue is representable.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fetch_if.sv
// Bundle of the fetch unit's memory, redirect and decode-side signals.
// The master modport is the fetch unit; slave is memory, EX and decode together.
interface fetch_if #(
  parameter int PC_W    = fetch_pkg::PC_W_DEF,
  parameter int INSTR_W = fetch_pkg::INSTR_W_DEF,
  parameter int DEPTH   = fetch_pkg::DEPTH_DEF
) ();
  import fetch_pkg::*;

  localparam int CNT_W = cnt_width(DEPTH);

  logic               imem_en;
  logic [PC_W-1:0]    imem_addr;
  logic [INSTR_W-1:0] imem_rdata;
  logic               redirect_valid;
  logic [PC_W-1:0]    redirect_pc;
  logic               dec_ready;
  logic               dec_valid;
  logic [INSTR_W-1:0] dec_instr;
  logic [PC_W-1:0]    dec_pc;
  logic [CNT_W-1:0]   q_count;

  modport master (
    output imem_en, imem_addr, dec_valid, dec_instr, dec_pc, q_count,
    input  imem_rdata, redirect_valid, redirect_pc, dec_ready
  );

  modport slave (
    input  imem_en, imem_addr, dec_valid, dec_instr, dec_pc, q_count,
    output imem_rdata, redirect_valid, redirect_pc, dec_ready
  );

endinterface

// File: rtl/fetch_queue.sv
// Synchronous FIFO of fetch entries with push, pop and a flush that beats both.
// The head entry reads as all-zeros whenever the queue is empty.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int  DEPTH   = DEPTH_DEF,
  parameter type entry_t = fetch_entry_t
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush_i,
  input  logic                  push_i,
  input  entry_t                push_data_i,
  input  logic                  pop_i,
  output entry_t                head_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = cnt_width(DEPTH);

  entry_t           mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push;
  logic             do_pop;

  // NOTE: every signal written here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    do_pop   = pop_i && (count_q != '0);
    do_push  = push_i && ((count_q != CNT_W'(DEPTH)) || do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // DEPTH is a power of two, so the pointers wrap on their own.
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: the storage array is deliberately not reset; an entry is only ever
  // read after it has been written, and the count gates the head output.
  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign head_o  = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
  assign count_o = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: issues sequential word reads, queues the
// returned instructions for decode, and restarts cleanly on EX redirects.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int              PC_W     = PC_W_DEF,
  parameter int              INSTR_W  = INSTR_W_DEF,
  parameter int              DEPTH    = DEPTH_DEF,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input logic      clk,
  input logic      rst,
  fetch_if.master  bus
);

  localparam int CNT_W = cnt_width(DEPTH);
  localparam int OCC_W = CNT_W + 1;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } entry_t;

  logic [PC_W-1:0]  fpc_q, fpc_d;
  logic [PC_W-1:0]  inflight_pc_q, inflight_pc_d;
  logic             inflight_q, inflight_d;
  logic             issue;
  logic             push;
  logic [OCC_W-1:0] credits_used;
  logic [CNT_W-1:0] count;
  entry_t           push_data;
  entry_t           head;

  // A read is only issued if its response is guaranteed a slot, even when
  // decode stalls: queued entries plus the outstanding read must stay below DEPTH.
  always_comb begin
    credits_used    = {1'b0, count} + OCC_W'(inflight_q);
    issue           = !rst && !bus.redirect_valid && (credits_used < OCC_W'(DEPTH));
    push            = inflight_q && !bus.redirect_valid;
    push_data.pc    = inflight_pc_q;
    push_data.instr = bus.imem_rdata;

    fpc_d         = fpc_q;
    inflight_d    = issue;
    inflight_pc_d = inflight_pc_q;
    if (bus.redirect_valid) begin
      fpc_d = bus.redirect_pc;
    end else if (issue) begin
      fpc_d         = fpc_q + PC_W'(1);
      inflight_pc_d = fpc_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fpc_q         <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
    end else begin
      fpc_q         <= fpc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
    end
  end

  fetch_queue #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_queue (
    .clk         (clk),
    .rst         (rst),
    .flush_i     (bus.redirect_valid),
    .push_i      (push),
    .push_data_i (push_data),
    .pop_i       (bus.dec_ready),
    .head_o      (head),
    .count_o     (count)
  );

  assign bus.imem_en   = issue;
  assign bus.imem_addr = fpc_q;
  assign bus.dec_valid = (count != '0);
  assign bus.dec_instr = head.instr;
  assign bus.dec_pc    = head.pc;
  assign bus.q_count   = count;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: a directed vector table, a stall/drain sequence, and a
// randomized run checked against a queue-based model of the fetch rules.
module tb_fetch_unit;

  localparam int          PC_W    = 12;
  localparam int          INSTR_W = 32;
  localparam int          DEPTH   = 4;
  localparam logic [31:0] IBASE   = 32'h1000_0000;

  typedef struct {
    logic        rst;
    logic        rv;
    logic [11:0] rpc;
    logic        rdy;
    logic        exp_valid;
    logic [11:0] exp_pc;
    int          exp_cnt;
    logic        exp_en;
    logic [11:0] exp_addr;
  } vec_t;

  logic clk;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;
  vec_t vecs[$];

  fetch_if #(.PC_W(PC_W), .INSTR_W(INSTR_W), .DEPTH(DEPTH)) bus ();

  fetch_unit #(
    .PC_W     (PC_W),
    .INSTR_W  (INSTR_W),
    .DEPTH    (DEPTH),
    .RESET_PC (12'h000)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Synchronous instruction memory: mem[a] = IBASE + a, one cycle read latency.
  always @(posedge clk) begin
    if (bus.imem_en) bus.imem_rdata <= IBASE + 32'(bus.imem_addr);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic rv, input logic [11:0] rpc, input logic rdy);
    @(negedge clk);
    rst                = r;
    bus.redirect_valid = rv;
    bus.redirect_pc    = rpc;
    bus.dec_ready      = rdy;
    #1;
  endtask

  task automatic check_outputs(input string tag, input logic ev, input logic [11:0] epc,
                               input int ecnt, input logic een, input logic [11:0] eaddr);
    check({tag, " dec_valid"}, 32'(bus.dec_valid), 32'(ev));
    check({tag, " dec_pc"},    32'(bus.dec_pc),    ev ? 32'(epc) : 32'h0);
    check({tag, " dec_instr"}, bus.dec_instr,      ev ? IBASE + 32'(epc) : 32'h0);
    check({tag, " q_count"},   32'(bus.q_count),   32'(ecnt));
    check({tag, " imem_en"},   32'(bus.imem_en),   32'(een));
    check({tag, " imem_addr"}, 32'(bus.imem_addr), 32'(eaddr));
  endtask

  task automatic add(input logic r, input logic rv, input logic [11:0] rpc, input logic rdy,
                     input logic ev, input logic [11:0] epc, input int ecnt,
                     input logic een, input logic [11:0] eaddr);
    vec_t v;
    v.rst = r; v.rv = rv; v.rpc = rpc; v.rdy = rdy;
    v.exp_valid = ev; v.exp_pc = epc; v.exp_cnt = ecnt; v.exp_en = een; v.exp_addr = eaddr;
    vecs.push_back(v);
  endtask

  // Reference model state: next fetch PC, outstanding read, queued PCs.
  logic [11:0] m_fpc;
  logic        m_infl;
  logic [11:0] m_infl_pc;
  logic [11:0] m_q[$];

  initial begin
    logic        r, rv, rdy, m_en;
    logic [11:0] rpc;

    rst = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.dec_ready      = 1'b1;

    // Columns: rst rv rpc rdy | valid pc count en addr
    add(1, 0, 12'h000, 1,  0, 12'h000, 0, 0, 12'h000);  // reset
    add(0, 0, 12'h000, 1,  0, 12'h000, 0, 1, 12'h000);  // first issue
    add(0, 0, 12'h000, 1,  0, 12'h000, 0, 1, 12'h001);
    add(0, 0, 12'h000, 1,  1, 12'h000, 1, 1, 12'h002);  // dec_valid at cycle 3
    add(0, 0, 12'h000, 1,  1, 12'h001, 1, 1, 12'h003);
    add(0, 0, 12'h000, 1,  1, 12'h002, 1, 1, 12'h004);
    add(0, 0, 12'h000, 0,  1, 12'h003, 1, 1, 12'h005);  // stall
    add(0, 0, 12'h000, 0,  1, 12'h003, 2, 1, 12'h006);
    add(0, 0, 12'h000, 0,  1, 12'h003, 3, 0, 12'h007);  // credit exhausted
    add(0, 0, 12'h000, 0,  1, 12'h003, 4, 0, 12'h007);
    add(0, 0, 12'h000, 0,  1, 12'h003, 4, 0, 12'h007);
    add(0, 0, 12'h000, 1,  1, 12'h003, 4, 0, 12'h007);  // release
    add(0, 0, 12'h000, 1,  1, 12'h004, 3, 1, 12'h007);
    add(0, 0, 12'h000, 1,  1, 12'h005, 2, 1, 12'h008);
    add(0, 0, 12'h000, 1,  1, 12'h006, 2, 1, 12'h009);
    add(0, 1, 12'h040, 1,  1, 12'h007, 2, 0, 12'h00A);  // redirect, 2 queued + 1 in flight
    add(0, 0, 12'h000, 1,  0, 12'h000, 0, 1, 12'h040);
    add(0, 0, 12'h000, 1,  0, 12'h000, 0, 1, 12'h041);
    add(0, 0, 12'h000, 1,  1, 12'h040, 1, 1, 12'h042);
    add(0, 0, 12'h000, 1,  1, 12'h041, 1, 1, 12'h043);
    add(0, 1, 12'h100, 1,  1, 12'h042, 1, 0, 12'h044);  // back-to-back redirects
    add(0, 1, 12'h200, 1,  0, 12'h000, 0, 0, 12'h100);
    add(0, 0, 12'h000, 1,  0, 12'h000, 0, 1, 12'h200);
    add(0, 0, 12'h000, 1,  0, 12'h000, 0, 1, 12'h201);
    add(0, 0, 12'h000, 1,  1, 12'h200, 1, 1, 12'h202);
    add(0, 0, 12'h000, 1,  1, 12'h201, 1, 1, 12'h203);
    add(0, 1, 12'hFFE, 1,  1, 12'h202, 1, 0, 12'h204);  // PC wrap
    add(0, 0, 12'h000, 1,  0, 12'h000, 0, 1, 12'hFFE);
    add(0, 0, 12'h000, 1,  0, 12'h000, 0, 1, 12'hFFF);
    add(0, 0, 12'h000, 1,  1, 12'hFFE, 1, 1, 12'h000);
    add(0, 0, 12'h000, 1,  1, 12'hFFF, 1, 1, 12'h001);
    add(0, 0, 12'h000, 1,  1, 12'h000, 1, 1, 12'h002);
    add(0, 0, 12'h000, 1,  1, 12'h001, 1, 1, 12'h003);
    add(0, 0, 12'h000, 0,  1, 12'h002, 1, 1, 12'h004);
    add(0, 0, 12'h000, 0,  1, 12'h002, 2, 1, 12'h005);
    add(1, 0, 12'h000, 0,  1, 12'h002, 3, 0, 12'h006);  // reset mid-stream
    add(0, 0, 12'h000, 1,  0, 12'h000, 0, 1, 12'h000);
    add(0, 0, 12'h000, 1,  0, 12'h000, 0, 1, 12'h001);
    add(0, 0, 12'h000, 1,  1, 12'h000, 1, 1, 12'h002);

    drive(1, 0, 12'h000, 1);
    drive(1, 0, 12'h000, 1);
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].rv, vecs[i].rpc, vecs[i].rdy);
      check_outputs($sformatf("vec%0d", i), vecs[i].exp_valid, vecs[i].exp_pc,
                    vecs[i].exp_cnt, vecs[i].exp_en, vecs[i].exp_addr);
    end

    // Stall straight out of reset: queue fills, head holds pc 0, then drains in order.
    drive(1, 0, 12'h000, 0);
    for (int i = 0; i < 10; i++) drive(0, 0, 12'h000, 0);
    check("stall q_count",   32'(bus.q_count),   32'd4);
    check("stall imem_en",   32'(bus.imem_en),   32'd0);
    check("stall dec_valid", 32'(bus.dec_valid), 32'd1);
    check("stall head pc",   32'(bus.dec_pc),    32'd0);
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 12'h000, 1);
      check($sformatf("drain%0d dec_valid", i), 32'(bus.dec_valid), 32'd1);
      check($sformatf("drain%0d dec_pc", i),    32'(bus.dec_pc),    32'(i));
      check($sformatf("drain%0d dec_instr", i), bus.dec_instr,      IBASE + 32'(i));
    end

    // Randomized run against the model.
    drive(1, 0, 12'h000, 1);
    m_fpc = 12'h000; m_infl = 1'b0; m_infl_pc = '0; m_q.delete();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      r   = ($urandom_range(0, 99) < 2);
      rv  = !r && ($urandom_range(0, 99) < 8);
      rpc = ($urandom_range(0, 3) == 0) ? 12'hFFC + 12'($urandom_range(0, 3))
                                        : 12'($urandom_range(0, 4095));
      rdy = ($urandom_range(0, 99) < 65);
      drive(r, rv, rpc, rdy);

      m_en = !r && !rv && ((m_q.size() + int'(m_infl)) < DEPTH);
      check_outputs($sformatf("rand%0d", cyc), m_q.size() != 0,
                    (m_q.size() != 0) ? m_q[0] : 12'h000, m_q.size(), m_en, m_fpc);

      if (r) begin
        m_fpc = 12'h000; m_infl = 1'b0; m_q.delete();
      end else if (rv) begin
        m_fpc = rpc; m_infl = 1'b0; m_q.delete();
      end else begin
        if (rdy && m_q.size() != 0) void'(m_q.pop_front());
        if (m_infl) m_q.push_back(m_infl_pc);
        m_infl = m_en;
        if (m_en) begin
          m_infl_pc = m_fpc;
          m_fpc     = m_fpc + 12'h001;
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
